time_set_controller: RTL and testbench

Sequencing controller for the time-clock datapath: runs a set-time FSM that freezes the hour/min/sec counter, lets the user edit hours then minutes with up/down buttons, and commits the new value with a one-cycle load pulse. It also selects the display mode (hour:min or sec:ms) and drives a per-digit blink mask for the FND scan path. It sits between the debounced buttons and the time counter / display mux / FND digit driver, and is clocked by the same divided clock as the counter.

---
 rtl/time_set_controller.sv | 181 ++++++++++++++++++
 tb/tb_time_set_controller.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/time_set_controller.sv
// rtl/time_set_controller.sv - set-time FSM, display-mode select and digit blink mask for the time counter
module time_set_controller #(
  parameter int TIMEOUT_CYC  = 10000,
  parameter int BLINK_HALF   = 500,
  parameter int REPEAT_DELAY = 500,
  parameter int REPEAT_RATE  = 100
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_btn_set,
  input  logic       i_btn_mode,
  input  logic       i_btn_up,
  input  logic       i_btn_down,
  input  logic [5:0] i_hour,
  input  logic [5:0] i_min,
  output logic       o_run,
  output logic       o_load,
  output logic [5:0] o_set_hour,
  output logic [5:0] o_set_min,
  output logic       o_disp_mode,
  output logic [3:0] o_blank,
  output logic [1:0] o_state
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int BW = $clog2(2 * BLINK_HALF + 1);
  localparam int RW = $clog2(REPEAT_DELAY + 1);

  localparam logic [TW-1:0] IDLE_LAST  = TW'(TIMEOUT_CYC - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(2 * BLINK_HALF - 1);
  localparam logic [BW-1:0] BLINK_MID  = BW'(BLINK_HALF);
  localparam logic [RW-1:0] RPT_FIRST  = RW'(1);
  localparam logic [RW-1:0] RPT_FIRE   = RW'(REPEAT_DELAY);
  // Reload so that the counter climbs back to RPT_FIRE after REPEAT_RATE cycles.
  localparam logic [RW-1:0] RPT_RELOAD = RW'(REPEAT_DELAY - REPEAT_RATE + 1);

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    SET_HOUR = 2'b01,
    SET_MIN  = 2'b10,
    COMMIT   = 2'b11
  } state_t;

  state_t state, state_next;

  logic set_lvl, mode_lvl, up_lvl, down_lvl;
  logic set_prev, mode_prev, up_prev, down_prev;
  logic set_edge, mode_edge, up_edge, down_edge;

  logic [5:0]    hour, minute, hour_next, minute_next;
  logic          disp_sel, disp_sel_next;
  logic          run, disp;
  logic [TW-1:0] idle_cnt, idle_next;
  logic [BW-1:0] blink_cnt, blink_next;
  logic [RW-1:0] rpt_cnt, rpt_next;
  logic          step, step_up;

  assign set_edge  = set_lvl  & ~set_prev;
  assign mode_edge = mode_lvl & ~mode_prev;
  assign up_edge   = up_lvl   & ~up_prev;
  assign down_edge = down_lvl & ~down_prev;

  always_comb begin
    state_next    = state;
    hour_next     = hour;
    minute_next   = minute;
    disp_sel_next = disp_sel;
    idle_next     = '0;
    blink_next    = '0;
    rpt_next      = '0;
    step          = 1'b0;
    step_up       = 1'b0;
    unique case (state)
      RUN: begin
        if (mode_edge) disp_sel_next = ~disp_sel;
        if (set_edge) begin
          hour_next   = (i_hour > 6'd23) ? 6'd0 : i_hour;
          minute_next = (i_min > 6'd59) ? 6'd0 : i_min;
          state_next  = SET_HOUR;
        end
      end
      SET_HOUR, SET_MIN: begin
        if (set_edge) begin
          state_next = (state == SET_HOUR) ? SET_MIN : COMMIT;
        end else begin
          if (up_lvl && down_lvl) begin
            rpt_next = '0;
          end else if (up_edge) begin
            step     = 1'b1;
            step_up  = 1'b1;
            rpt_next = RPT_FIRST;
          end else if (down_edge) begin
            step     = 1'b1;
            rpt_next = RPT_FIRST;
          end else if ((up_lvl || down_lvl) && rpt_cnt != '0) begin
            if (rpt_cnt == RPT_FIRE) begin
              step     = 1'b1;
              step_up  = up_lvl;
              rpt_next = RPT_RELOAD;
            end else begin
              rpt_next = rpt_cnt + 1'b1;
            end
          end
          blink_next = (step || blink_cnt == BLINK_LAST) ? '0 : blink_cnt + 1'b1;
          if (step || mode_edge || up_edge || down_edge) begin
            idle_next = '0;
          end else if (idle_cnt == IDLE_LAST) begin
            state_next = RUN;
          end else begin
            idle_next = idle_cnt + 1'b1;
          end
          if (step && state == SET_HOUR) begin
            if (step_up) hour_next = (hour == 6'd23) ? 6'd0 : hour + 6'd1;
            else         hour_next = (hour == 6'd0) ? 6'd23 : hour - 6'd1;
          end else if (step) begin
            if (step_up) minute_next = (minute == 6'd59) ? 6'd0 : minute + 6'd1;
            else         minute_next = (minute == 6'd0) ? 6'd59 : minute - 6'd1;
          end
        end
      end
      default: state_next = RUN;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state     <= RUN;
      set_lvl   <= 1'b1;
      mode_lvl  <= 1'b1;
      up_lvl    <= 1'b1;
      down_lvl  <= 1'b1;
      set_prev  <= 1'b1;
      mode_prev <= 1'b1;
      up_prev   <= 1'b1;
      down_prev <= 1'b1;
      hour      <= 6'd0;
      minute    <= 6'd0;
      disp_sel  <= 1'b0;
      run       <= 1'b1;
      disp      <= 1'b0;
      idle_cnt  <= '0;
      blink_cnt <= '0;
      rpt_cnt   <= '0;
    end else begin
      state     <= state_next;
      set_lvl   <= i_btn_set;
      mode_lvl  <= i_btn_mode;
      up_lvl    <= i_btn_up;
      down_lvl  <= i_btn_down;
      set_prev  <= set_lvl;
      mode_prev <= mode_lvl;
      up_prev   <= up_lvl;
      down_prev <= down_lvl;
      hour      <= hour_next;
      minute    <= minute_next;
      disp_sel  <= disp_sel_next;
      run       <= (state_next == RUN);
      // The stored mode survives the edit; only the visible copy is forced to 0.
      disp      <= (state_next == RUN) && disp_sel_next;
      idle_cnt  <= idle_next;
      blink_cnt <= blink_next;
      rpt_cnt   <= rpt_next;
    end
  end

  always_comb begin
    o_blank = 4'b0000;
    if (blink_cnt >= BLINK_MID) begin
      if (state == SET_HOUR)     o_blank = 4'b1100;
      else if (state == SET_MIN) o_blank = 4'b0011;
    end
  end

  assign o_load      = (state == COMMIT);
  assign o_run       = run;
  assign o_disp_mode = disp;
  assign o_set_hour  = hour;
  assign o_set_min   = minute;
  assign o_state     = state;

endmodule

// File: tb/tb_time_set_controller.sv
// tb/tb_time_set_controller.sv - self-checking bench for time_set_controller
module tb_time_set_controller;

  localparam int TO = 50;
  localparam int BH = 4;
  localparam int RD = 8;
  localparam int RR = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       b_set, b_mode, b_up, b_dn;
  logic [5:0] in_hour, in_min;
  logic       o_run, o_load, o_disp_mode;
  logic [5:0] o_set_hour, o_set_min;
  logic [3:0] o_blank;
  logic [1:0] o_state;

  int compared   = 0;
  int mismatched = 0;
  int load_cnt   = 0;
  int cyc        = 0;
  bit started    = 0;

  time_set_controller #(
    .TIMEOUT_CYC(TO), .BLINK_HALF(BH), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
  ) dut (
    .i_clk(clk), .i_reset(rst),
    .i_btn_set(b_set), .i_btn_mode(b_mode), .i_btn_up(b_up), .i_btn_down(b_dn),
    .i_hour(in_hour), .i_min(in_min),
    .o_run(o_run), .o_load(o_load), .o_set_hour(o_set_hour), .o_set_min(o_set_min),
    .o_disp_mode(o_disp_mode), .o_blank(o_blank), .o_state(o_state)
  );

  always #5 clk = ~clk;

  // Model: buttons are seen one edge late (s_*), edges against the previous sample (p_*).
  int m_state, m_hour, m_min, m_mode, m_idle, m_blink, m_rep, m_k;
  bit s_set, s_mode, s_up, s_dn, p_set, p_mode, p_up, p_dn;

  always @(posedge clk) begin : model_cmp
    bit e_set, e_mode, e_up, e_dn, act;
    int step, w_blank, w_disp;
    cyc++;
    if (rst) begin
      m_state = 0; m_hour = 0; m_min = 0; m_mode = 0;
      m_idle = 0; m_blink = 0; m_rep = 0; m_k = 0;
      {s_set, s_mode, s_up, s_dn} = 4'hF;
      {p_set, p_mode, p_up, p_dn} = 4'hF;
      started = 1;
    end else begin
      e_set = s_set && !p_set; e_mode = s_mode && !p_mode;
      e_up = s_up && !p_up;    e_dn = s_dn && !p_dn;
      {p_set, p_mode, p_up, p_dn} = {s_set, s_mode, s_up, s_dn};
      act = e_set || e_mode || e_up || e_dn;
      step = 0;
      case (m_state)
        0: begin
          if (e_mode) m_mode = 1 - m_mode;
          if (e_set) begin
            m_hour = (in_hour > 23) ? 0 : int'(in_hour);
            m_min = (in_min > 59) ? 0 : int'(in_min);
            m_state = 1; m_idle = 0; m_blink = 0; m_rep = 0;
          end
        end
        1, 2: begin
          if (e_set) begin
            m_state = (m_state == 1) ? 2 : 3;
            m_idle = 0; m_blink = 0; m_rep = 0;
          end else begin
            if (s_up && s_dn) m_rep = 0;
            else if (e_up) begin step = 1; m_rep = 1; m_k = 0; end
            else if (e_dn) begin step = -1; m_rep = 2; m_k = 0; end
            else if ((m_rep == 1 && s_up) || (m_rep == 2 && s_dn)) begin
              m_k++;
              if (m_k >= RD && (m_k - RD) % RR == 0) step = (m_rep == 1) ? 1 : -1;
            end else m_rep = 0;
            if (step != 0) begin
              if (m_state == 1) m_hour = (m_hour + step + 24) % 24;
              else              m_min = (m_min + step + 60) % 60;
              m_blink = 0;
            end else m_blink++;
            if (act || step != 0) m_idle = 0;
            else begin
              m_idle++;
              if (m_idle == TO) begin m_state = 0; m_idle = 0; end
            end
          end
        end
        default: m_state = 0;
      endcase
      {s_set, s_mode, s_up, s_dn} = {b_set, b_mode, b_up, b_dn};
    end
    #1;
    if (o_load) load_cnt++;
    if (started) begin
      w_blank = 0;
      if ((m_state == 1 || m_state == 2) && ((m_blink / BH) % 2 == 1))
        w_blank = (m_state == 1) ? 4'b1100 : 4'b0011;
      w_disp = (m_state == 0) ? m_mode : 0;
      compared++;
      if (o_state != m_state || o_run != (m_state == 0) || o_load != (m_state == 3) ||
          o_set_hour != m_hour || o_set_min != m_min || o_disp_mode != w_disp ||
          o_blank != w_blank) begin
        mismatched++;
        $display("FAIL model cycle %0d: got st=%0d run=%0d ld=%0d h=%0d m=%0d dm=%0d bl=%b want st=%0d run=%0d ld=%0d h=%0d m=%0d dm=%0d bl=%b",
                 cyc, o_state, o_run, o_load, o_set_hour, o_set_min, o_disp_mode, o_blank,
                 m_state, m_state == 0, m_state == 3, m_hour, m_min, w_disp, w_blank[3:0]);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string name, input int got, input int want);
    compared++;
    if (got != want) begin
      mismatched++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  task automatic press(input int which);
    case (which)
      0: b_set = 1'b1;
      1: b_mode = 1'b1;
      2: b_up = 1'b1;
      default: b_dn = 1'b1;
    endcase
    tick(1);
    {b_set, b_mode, b_up, b_dn} = 4'b0000;
    tick(1);
  endtask

  initial begin : drive
    int loads0;
    int want_bl;
    rst = 1'b1;
    {b_set, b_mode, b_up, b_dn} = 4'b0000;
    in_hour = 6'd0; in_min = 6'd0;
    tick(2);
    chk("reset_state", o_state, 0);
    chk("reset_run", o_run, 1);
    chk("reset_load", o_load, 0);
    chk("reset_hour", o_set_hour, 0);
    chk("reset_min", o_set_min, 0);
    chk("reset_blank", o_blank, 0);
    chk("reset_disp", o_disp_mode, 0);
    rst = 1'b0;
    tick(1);

    press(1);
    chk("mode_toggle", o_disp_mode, 1);

    in_hour = 6'd22; in_min = 6'd58;
    press(0);
    chk("enter_state", o_state, 1);
    chk("capture_hour", o_set_hour, 22);
    chk("disp_forced", o_disp_mode, 0);
    press(2); chk("hour_up1", o_set_hour, 23);
    press(2); chk("hour_wrap", o_set_hour, 0);
    press(0); chk("to_set_min", o_state, 2);
    press(2); chk("min_up1", o_set_min, 59);
    press(2); chk("min_wrap", o_set_min, 0);
    press(0);
    chk("commit_load", o_load, 1);
    chk("commit_hour", o_set_hour, 0);
    chk("commit_run", o_run, 0);
    tick(1);
    chk("after_commit_run", o_run, 1);
    chk("after_commit_load", o_load, 0);
    chk("mode_restored", o_disp_mode, 1);

    in_hour = 6'd0; in_min = 6'd0;
    press(0);
    press(1);
    chk("mode_ignored_disp", o_disp_mode, 0);
    chk("mode_ignored_state", o_state, 1);
    press(3); chk("hour_down_wrap", o_set_hour, 23);
    press(0);
    press(3); chk("min_down_wrap", o_set_min, 59);
    press(0);
    tick(1);
    chk("mode_kept", o_disp_mode, 1);

    in_hour = 6'd5; in_min = 6'd10;
    press(0);
    for (int i = 0; i < 12; i++) begin
      want_bl = (i >= 4 && i < 8) ? 4'b1100 : 4'b0000;
      chk($sformatf("blink_%0d", i), o_blank, want_bl);
      tick(1);
    end
    b_up = 1'b1; b_dn = 1'b1; tick(1);
    b_up = 1'b0; b_dn = 1'b0; tick(1);
    chk("updown_nochange", o_set_hour, 5);
    b_set = 1'b1; b_up = 1'b1; tick(1);
    b_set = 1'b0; b_up = 1'b0; tick(1);
    chk("set_beats_up_state", o_state, 2);
    chk("set_beats_up_hour", o_set_hour, 5);

    b_up = 1'b1; tick(17);
    b_up = 1'b0; tick(1);
    chk("repeat_final", o_set_min, 16);
    press(0);
    tick(1);

    loads0 = load_cnt;
    press(0);
    tick(TO - 1);
    chk("pre_timeout_state", o_state, 1);
    tick(1);
    chk("timeout_state", o_state, 0);
    chk("timeout_run", o_run, 1);
    chk("timeout_no_load", load_cnt - loads0, 0);
    chk("timeout_keeps_hour", o_set_hour, 5);

    press(0);
    press(0);
    press(2);
    chk("mid_edit_state", o_state, 2);
    rst = 1'b1;
    tick(1);
    chk("midreset_state", o_state, 0);
    chk("midreset_run", o_run, 1);
    chk("midreset_load", o_load, 0);
    chk("midreset_hour", o_set_hour, 0);
    chk("midreset_min", o_set_min, 0);
    chk("midreset_disp", o_disp_mode, 0);
    chk("midreset_blank", o_blank, 0);
    rst = 1'b0;
    tick(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
